// File: rtl/coh_pkg.sv
// coh_pkg: shared types and constants for the write-back coherency controller.
//   coh_state_t : controller FSM states
//   LINE_VALID / LINE_DIRTY / LINE_CLEAN : per-line status bit values
//   coh_line_t  : line data word at the default line width
package coh_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      DIRTY,
      INVAL,
      WB,
      CLEAN,
      RESP
   } coh_state_t;

   localparam logic LINE_VALID = 1'b1;
   localparam logic LINE_DIRTY = 1'b1;
   localparam logic LINE_CLEAN = 1'b0;

   localparam int unsigned COH_DATA_W = 16;
   typedef logic [COH_DATA_W-1:0] coh_line_t;

endpackage

// File: rtl/coh_ack_collector.sv
// coh_ack_collector: gathers per-remote invalidate acknowledges into a sticky mask.
// Optional build macro: COH_ACK_TIMEOUT_EN (adds an INVAL cycle counter and timeout flag).
// Ports:
//   clk       in   clock
//   clr       in   clear mask (and counter)
//   en        in   collecting (controller is in INVAL)
//   ack       in   N_REMOTE acknowledge bits
//   all_acked out  (mask | ack) is all ones, combinational
//   timeout   out  ACK_TIMEOUT-th collecting cycle without full mask (macro only)
module coh_ack_collector #(
   parameter int unsigned N_REMOTE    = 2
`ifdef COH_ACK_TIMEOUT_EN
   , parameter int unsigned ACK_TIMEOUT = 64
`endif
) (
   input  logic                clk,
   input  logic                clr,
   input  logic                en,
   input  logic [N_REMOTE-1:0] ack,
   output logic                all_acked
`ifdef COH_ACK_TIMEOUT_EN
   , output logic              timeout
`endif
);

   logic [N_REMOTE-1:0] mask;

   // Includes this cycle's acks so the controller can leave in the same cycle.
   assign all_acked = &(mask | ack);

   always_ff @(posedge clk) begin
      if (clr) begin
         mask <= '0;
      end else if (en) begin
         mask <= mask | ack;
      end
   end

`ifdef COH_ACK_TIMEOUT_EN
   localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != CNT_LAST)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Fires on the ACK_TIMEOUT-th cycle of collection; the caller gives all_acked priority.
   assign timeout = en && (cnt == CNT_LAST);
`endif

endmodule

// File: rtl/wb_coherency_ctrl.sv
// wb_coherency_ctrl: write-back write-hit coherency controller for one local cache.
// Each accepted write: lookup, write+dirty, invalidate remotes, write back, clean, respond.
// Optional build macro: COH_ACK_TIMEOUT_EN (abort INVAL after ACK_TIMEOUT cycles).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   wr_valid/wr_ready        core write handshake; wr_addr/wr_data request
//   fill_valid/addr/data     install a valid, clean line (IDLE only, beats writes)
//   wr_done/wr_hit/wr_err    one-cycle response
//   bus_req/inval_addr/ack   invalidate broadcast and per-remote acks
//   mem_wr_valid/ready/addr/data  write-back channel
//   busy                     controller not idle
module wb_coherency_ctrl
   import coh_pkg::*;
#(
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned N_REMOTE    = 2,
   parameter int unsigned ACK_TIMEOUT = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_valid,
   output logic                wr_ready,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic                fill_valid,
   input  logic [ADDR_W-1:0]   fill_addr,
   input  logic [DATA_W-1:0]   fill_data,
   output logic                wr_done,
   output logic                wr_hit,
   output logic                wr_err,
   output logic                bus_req,
   output logic [ADDR_W-1:0]   inval_addr,
   input  logic [N_REMOTE-1:0] ack,
   output logic                mem_wr_valid,
   input  logic                mem_wr_ready,
   output logic [ADDR_W-1:0]   mem_wr_addr,
   output logic [DATA_W-1:0]   mem_wr_data,
   output logic                busy
);

   localparam int unsigned DEPTH = 2**ADDR_W;

   coh_state_t        state;
   logic [DEPTH-1:0]  valid;
   logic [DEPTH-1:0]  dirty;
   logic [DATA_W-1:0] data_arr [DEPTH];
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic              wb_q;
   logic              all_acked;
   logic              coll_clr;
   logic              coll_en;

   assign coll_en  = (state == INVAL);
   assign coll_clr = rst || (state != INVAL);

`ifdef COH_ACK_TIMEOUT_EN
   logic timeout;
   logic err_q;

   coh_ack_collector #(
      .N_REMOTE    (N_REMOTE),
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) u_ack (
      .clk       (clk),
      .clr       (coll_clr),
      .en        (coll_en),
      .ack       (ack),
      .all_acked (all_acked),
      .timeout   (timeout)
   );

   assign wr_err = err_q;
`else
   coh_ack_collector #(
      .N_REMOTE (N_REMOTE)
   ) u_ack (
      .clk       (clk),
      .clr       (coll_clr),
      .en        (coll_en),
      .ack       (ack),
      .all_acked (all_acked)
   );

   assign wr_err = 1'b0;
`endif

   // Fill wins over a write in IDLE, so the write is refused in the fill cycle.
   assign wr_ready = !busy && !fill_valid;

   // Only a dirty line is written back; outputs read zero when idle on the channel.
   assign mem_wr_valid = wb_q && (dirty[addr_q] == LINE_DIRTY);
   assign mem_wr_addr  = mem_wr_valid ? addr_q : '0;
   assign mem_wr_data  = mem_wr_valid ? data_arr[addr_q] : '0;
   assign inval_addr   = bus_req ? addr_q : '0;

   // Data array is deliberately not reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if ((state == IDLE) && fill_valid) begin
            data_arr[fill_addr] <= fill_data;
         end else if (state == DIRTY) begin
            data_arr[addr_q] <= data_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         valid   <= '0;
         dirty   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         wb_q    <= 1'b0;
         bus_req <= 1'b0;
         wr_done <= 1'b0;
         wr_hit  <= 1'b0;
         busy    <= 1'b0;
`ifdef COH_ACK_TIMEOUT_EN
         err_q   <= 1'b0;
`endif
      end else begin
         wr_done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (fill_valid) begin
                  valid[fill_addr] <= LINE_VALID;
                  dirty[fill_addr] <= LINE_CLEAN;
               end else if (wr_valid) begin
                  addr_q <= wr_addr;
                  data_q <= wr_data;
                  busy   <= 1'b1;
                  state  <= LOOKUP;
               end
            end
            LOOKUP: begin
               if (valid[addr_q] == LINE_VALID) begin
                  state <= DIRTY;
               end else begin
                  wr_done <= 1'b1;
                  wr_hit  <= 1'b0;
                  state   <= RESP;
               end
            end
            DIRTY: begin
               dirty[addr_q] <= LINE_DIRTY;
               bus_req       <= 1'b1;
               state         <= INVAL;
            end
            INVAL: begin
               if (all_acked) begin
                  bus_req <= 1'b0;
                  wb_q    <= 1'b1;
                  state   <= WB;
`ifdef COH_ACK_TIMEOUT_EN
               end else if (timeout) begin
                  // Abandon the broadcast; the line stays dirty and is not written back.
                  bus_req <= 1'b0;
                  wr_done <= 1'b1;
                  wr_hit  <= 1'b1;
                  err_q   <= 1'b1;
                  state   <= RESP;
`endif
               end
            end
            WB: begin
               if (mem_wr_ready) begin
                  wb_q  <= 1'b0;
                  state <= CLEAN;
               end
            end
            CLEAN: begin
               dirty[addr_q] <= LINE_CLEAN;
               wr_done       <= 1'b1;
               wr_hit        <= 1'b1;
               state         <= RESP;
            end
            RESP: begin
               wr_hit <= 1'b0;
`ifdef COH_ACK_TIMEOUT_EN
               err_q  <= 1'b0;
`endif
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               bus_req <= 1'b0;
               wb_q    <= 1'b0;
               wr_hit  <= 1'b0;
               busy    <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_coherency_ctrl.sv
// tb_wb_coherency_ctrl: self-checking bench for wb_coherency_ctrl.
// Directed cases plus randomized fills/writes with random ack and memory-ready delays,
// checked cycle by cycle against a transaction-level timing model.
// Honours COH_ACK_TIMEOUT_EN (ACK_TIMEOUT overridden to 8).
module tb_wb_coherency_ctrl;

   localparam int unsigned ADDR_W   = 10;
   localparam int unsigned DATA_W   = 16;
   localparam int unsigned N_REMOTE = 2;
   localparam int          TO       = 8;

   logic                clk = 1'b0;
   logic                rst;
   logic                wr_valid;
   logic                wr_ready;
   logic [ADDR_W-1:0]   wr_addr;
   logic [DATA_W-1:0]   wr_data;
   logic                fill_valid;
   logic [ADDR_W-1:0]   fill_addr;
   logic [DATA_W-1:0]   fill_data;
   logic                wr_done;
   logic                wr_hit;
   logic                wr_err;
   logic                bus_req;
   logic [ADDR_W-1:0]   inval_addr;
   logic [N_REMOTE-1:0] ack;
   logic                mem_wr_valid;
   logic                mem_wr_ready;
   logic [ADDR_W-1:0]   mem_wr_addr;
   logic [DATA_W-1:0]   mem_wr_data;
   logic                busy;

   int n_cmp = 0;
   int n_bad = 0;
   bit [1023:0] model_valid;

   always #5 clk = ~clk;

   wb_coherency_ctrl #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .N_REMOTE    (N_REMOTE),
      .ACK_TIMEOUT (TO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .fill_valid   (fill_valid),
      .fill_addr    (fill_addr),
      .fill_data    (fill_data),
      .wr_done      (wr_done),
      .wr_hit       (wr_hit),
      .wr_err       (wr_err),
      .bus_req      (bus_req),
      .inval_addr   (inval_addr),
      .ack          (ack),
      .mem_wr_valid (mem_wr_valid),
      .mem_wr_ready (mem_wr_ready),
      .mem_wr_addr  (mem_wr_addr),
      .mem_wr_data  (mem_wr_data),
      .busy         (busy)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic idle_inputs();
      wr_valid     = 1'b0;
      fill_valid   = 1'b0;
      ack          = '0;
      mem_wr_ready = 1'b0;
   endtask

   // Fill in IDLE with a competing write request: fill must win.
   task automatic do_fill(input int a, input logic [DATA_W-1:0] d);
      @(negedge clk);
      fill_valid = 1'b1;
      fill_addr  = ADDR_W'(a);
      fill_data  = d;
      wr_valid   = 1'($urandom_range(0, 1));
      wr_addr    = ADDR_W'(a);
      wr_data    = ~d;
      #1 check_eq("fill_wr_ready", wr_ready, 0);
      @(negedge clk);
      check_eq("fill_no_accept", busy, 0);
      idle_inputs();
      model_valid[a] = 1'b1;
   endtask

   // One write. del0/del1: ack offset from INVAL entry; rdel: cycles mem_wr_ready held low.
   // Cycle k counts from the accept edge; noise is driven on inputs the controller must ignore.
   task automatic do_write(input int a, input logic [DATA_W-1:0] d,
                           input int del0, input int del1, input int rdel);
      bit hit, to, exp_bus, exp_mem;
      int dmax, last, resp_k, wb_lo, wb_hi;
      hit  = model_valid[a];
      dmax = (del0 > del1) ? del0 : del1;
      to   = 1'b0;
`ifdef COH_ACK_TIMEOUT_EN
      if (dmax >= TO) to = 1'b1;
`endif
      last   = to ? (3 + TO - 1) : (3 + dmax);
      wb_lo  = last + 1;
      wb_hi  = last + 1 + rdel;
      resp_k = !hit ? 2 : (to ? last + 1 : wb_hi + 2);

      @(negedge clk);
      check_eq("pre_wr_ready", wr_ready, 1);
      check_eq("pre_busy", busy, 0);
      wr_valid = 1'b1;
      wr_addr  = ADDR_W'(a);
      wr_data  = d;

      for (int k = 1; k <= resp_k + 1; k++) begin
         @(negedge clk);
         exp_bus = hit && (k >= 3) && (k <= last);
         exp_mem = hit && !to && (k >= wb_lo) && (k <= wb_hi);
         check_eq("bus_req", bus_req, exp_bus);
         check_eq("inval_addr", inval_addr, exp_bus ? a : 0);
         check_eq("mem_wr_valid", mem_wr_valid, exp_mem);
         check_eq("mem_wr_addr", mem_wr_addr, exp_mem ? a : 0);
         check_eq("mem_wr_data", mem_wr_data, exp_mem ? d : 0);
         check_eq("wr_done", wr_done, k == resp_k);
         check_eq("wr_hit", wr_hit, (k == resp_k) && hit);
         check_eq("wr_err", wr_err, (k == resp_k) && to);
         check_eq("busy", busy, k <= resp_k);
         check_eq("wr_ready", wr_ready, k > resp_k);

         if (k > resp_k) begin
            idle_inputs();
         end else begin
            if (exp_bus) begin
               ack[0] = (k == 3 + del0);
               ack[1] = (k == 3 + del1);
            end else begin
               ack = N_REMOTE'($urandom);
            end
            mem_wr_ready = exp_mem ? (k == wb_hi) : 1'($urandom);
            fill_valid   = (k < resp_k) ? 1'($urandom) : 1'b0;
            fill_addr    = ADDR_W'($urandom_range(0, 15));
            fill_data    = DATA_W'($urandom);
            wr_valid     = (k < resp_k) ? 1'($urandom) : 1'b0;
            wr_addr      = ADDR_W'($urandom_range(0, 15));
            wr_data      = DATA_W'($urandom);
         end
      end
   endtask

   initial begin
      model_valid = '0;
      rst = 1'b1;
      idle_inputs();
      wr_addr = '0;
      wr_data = '0;
      fill_addr = '0;
      fill_data = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_eq("rst_wr_ready", wr_ready, 1);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_wr_done", wr_done, 0);
      check_eq("rst_wr_hit", wr_hit, 0);
      check_eq("rst_wr_err", wr_err, 0);
      check_eq("rst_bus_req", bus_req, 0);
      check_eq("rst_inval_addr", inval_addr, 0);
      check_eq("rst_mem_wr_valid", mem_wr_valid, 0);
      check_eq("rst_mem_wr_addr", mem_wr_addr, 0);
      check_eq("rst_mem_wr_data", mem_wr_data, 0);

      // Basic hit with same-cycle acks and ready, then a miss.
      do_fill(5, 16'h1111);
      do_write(5, 16'hBEEF, 0, 0, 0);
      do_write(7, 16'h1234, 0, 0, 0);
      // Split acks, then memory back-pressure on a back-to-back hit to the same line.
      do_fill(9, 16'h2222);
      do_write(9, 16'hCAFE, 1, 4, 0);
      do_write(9, 16'hF00D, 0, 0, 3);
      do_write(9, 16'h0F0F, 3, 0, 1);

      // Reset while in INVAL clears valid bits.
      do_fill(48, 16'h3333);
      @(negedge clk);
      wr_valid = 1'b1;
      wr_addr  = ADDR_W'(48);
      wr_data  = 16'h5A5A;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         idle_inputs();
         if (k == 4) check_eq("mid_bus_req", bus_req, 1);
      end
      rst = 1'b1;
      @(negedge clk);
      check_eq("midrst_busy", busy, 0);
      check_eq("midrst_bus_req", bus_req, 0);
      check_eq("midrst_wr_ready", wr_ready, 1);
      rst = 1'b0;
      @(negedge clk);
      check_eq("postrst_busy", busy, 0);
      check_eq("postrst_bus_req", bus_req, 0);
      check_eq("postrst_mem_wr_valid", mem_wr_valid, 0);
      check_eq("postrst_wr_done", wr_done, 0);
      check_eq("postrst_wr_ready", wr_ready, 1);
      model_valid = '0;
      do_write(48, 16'h6666, 0, 0, 0);

`ifdef COH_ACK_TIMEOUT_EN
      // Remote 1 never acks.
      do_fill(17, 16'h4444);
      do_write(17, 16'h7777, 2, 100, 0);
`endif

      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            do_fill($urandom_range(0, 15), DATA_W'($urandom));
         end else begin
            do_write($urandom_range(0, 15), DATA_W'($urandom),
                     $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 3));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
